// File: rtl/ctrl_pkg.sv
// Shared control-word layout and pipeline stage indices for the datapath.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 8;

  // Bit positions inside one control word.
  localparam int unsigned CTRL_BRANCH    = 0;
  localparam int unsigned CTRL_MEMREAD   = 1;
  localparam int unsigned CTRL_MEMTOREG  = 2;
  localparam int unsigned CTRL_MEMWRITE  = 3;
  localparam int unsigned CTRL_ALUOP_LSB = 4;  // 2-bit field
  localparam int unsigned CTRL_ALUSRC    = 6;
  localparam int unsigned CTRL_REGWRITE  = 7;

  typedef enum logic [2:0] {
    STG_EX  = 3'd0,
    STG_MEM = 3'd1,
    STG_WB  = 3'd2
  } stage_e;

endpackage

// File: rtl/ctrl_stage.sv
// One control pipeline stage: word + valid register with flush/freeze/load.
// Flush beats freeze; freeze beats load.
module ctrl_stage #(
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              freeze_i,
  input  logic [CTRL_W-1:0] word_i,
  input  logic              valid_i,
  output logic [CTRL_W-1:0] word_o,
  output logic              valid_o
);

  logic [CTRL_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  // Next-state selection: hold by default, flush clears, otherwise load when not frozen.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (flush_i) begin
      word_d  = '0;
      valid_d = 1'b0;
    end else if (!freeze_i) begin
      word_d  = word_i;
      valid_d = valid_i;
    end
  end

  // Stage register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o  = word_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Parametrised control-bundle pipeline (EX, MEM, WB, ...).
// Optional bubble statistics counter enabled by defining CTRL_PIPE_STATS_EN.
module ctrl_pipe #(
  parameter int unsigned CTRL_W = ctrl_pkg::CTRL_W,
  parameter int unsigned DEPTH  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CTRL_W-1:0]       ctrl_in,
  input  logic                    valid_in,
  input  logic                    bubble,
  input  logic                    freeze,
  input  logic [DEPTH-1:0]        flush,
  output logic [DEPTH*CTRL_W-1:0] ctrl_out,
  output logic [DEPTH-1:0]        valid_out,
  output logic [15:0]             bubble_count
);

  import ctrl_pkg::*;

  localparam int unsigned Stage0 = STG_EX;

  logic [CTRL_W-1:0] load_word  [DEPTH];
  logic              load_valid [DEPTH];
  logic [CTRL_W-1:0] stage_word [DEPTH];
  logic              stage_valid[DEPTH];

  // Stage-0 bubble select: a bubble or an idle slot enters as an all-zero invalid word.
  always_comb begin
    load_word[Stage0]  = ctrl_in;
    load_valid[Stage0] = 1'b1;
    if (bubble || !valid_in) begin
      load_word[Stage0]  = '0;
      load_valid[Stage0] = 1'b0;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign load_word[k]  = stage_word[k-1];
      assign load_valid[k] = stage_valid[k-1];
    end

    ctrl_stage #(
      .CTRL_W (CTRL_W)
    ) u_stage (
      .clk_i    (clk),
      .rst_i    (reset),
      .flush_i  (flush[k]),
      .freeze_i (freeze),
      .word_i   (load_word[k]),
      .valid_i  (load_valid[k]),
      .word_o   (stage_word[k]),
      .valid_o  (stage_valid[k])
    );

    assign ctrl_out[k*CTRL_W +: CTRL_W] = stage_word[k];
    assign valid_out[k]                 = stage_valid[k];
  end

`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Count bubbles that actually enter stage 0; saturate rather than wrap.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && !freeze && !flush[Stage0] && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_count = bubble_cnt_q;
`else
  assign bubble_count = 16'h0000;
`endif

endmodule
